// File: rtl/mux16_rr_arbiter_pkg.sv
// Shared types and constants for the two-source round-robin 16-bit channel arbiter.
// Holds the state encoding, the source indices and the default datapath widths.
package mux16_rr_arbiter_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

endpackage

// File: rtl/mux16_rr_arbiter_pick2.sv
// Combinational two-way round-robin pick.
// On a tie the source that did not win last time is chosen. With no requests the pointer is held.
module rr_pick2
  import mux16_rr_arbiter_pkg::*;
(
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_last_grant,
  output logic o_grant,
  output logic o_any_valid
);

  always_comb begin
    o_any_valid = i_valid0 | i_valid1;
    o_grant     = i_last_grant;
    if (i_valid0 && !i_valid1) begin
      o_grant = SRC0;
    end else if (!i_valid0 && i_valid1) begin
      o_grant = SRC1;
    end else if (i_valid0 && i_valid1) begin
      o_grant = ~i_last_grant;
    end
  end

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Two requesters share one 16-bit channel through a round-robin 2:1 mux.
// The selected word is captured in a one-entry output stage that supports back-to-back transfers.
module mux16_rr_arbiter
  import mux16_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic             mux_sel,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic             r_last_grant;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_src;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic             w_grant;
  logic             w_any_valid;
  logic             w_can_load;
  logic             w_xfer;
  logic [WIDTH-1:0] w_mux_data;

  rr_pick2 u_pick (
    .i_valid0     (req0_valid),
    .i_valid1     (req1_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_any_valid  (w_any_valid)
  );

  // Readies are masked while reset is held so no handshake completes during reset.
  assign w_can_load = rst_n && ((r_state == ST_IDLE) || out_ready);
  assign w_xfer     = w_can_load && w_any_valid;
  assign w_mux_data = (w_grant == SRC1) ? req1_data : req0_data;

  assign req0_ready = w_can_load && req0_valid && (w_grant == SRC0);
  assign req1_ready = w_can_load && req1_valid && (w_grant == SRC1);

  assign mux_sel   = w_grant;
  assign out_valid = (r_state == ST_HOLD);
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign cnt0      = r_cnt0;
  assign cnt1      = r_cnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= SRC1;
      r_out_data   <= '0;
      r_out_src    <= SRC0;
      r_cnt0       <= '0;
      r_cnt1       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ready && !w_xfer) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_xfer) begin
        r_out_data   <= w_mux_data;
        r_out_src    <= w_grant;
        r_last_grant <= w_grant;
        if (w_grant == SRC0) begin
          r_cnt0 <= r_cnt0 + CNT_ONE;
        end else begin
          r_cnt1 <= r_cnt1 + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Directed self-checking bench for mux16_rr_arbiter.
// Inputs change 1ns after a rising edge; outputs are sampled before the next edge.
module tb_mux16_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid;
  logic [15:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [15:0] req1_data;
  logic        req1_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_src;
  logic        out_ready;
  logic        mux_sel;
  logic [7:0]  cnt0;
  logic [7:0]  cnt1;

  int checks;
  int errors;

  mux16_rr_arbiter #(.WIDTH(16), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_ready  (out_ready),
    .mux_sel    (mux_sel),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = 16'h0000;
    req1_data  = 16'h0000;
    out_ready  = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] d0;
    logic [15:0] d1;
    d0 = 16'($urandom);
    d1 = 16'($urandom);
    @(posedge clk);
    #1;
    rst_n      = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = d0;
    req1_data  = d1;
    out_ready  = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (cnt0 !== 8'h00 || cnt1 !== 8'h00) begin errors++; $display("[TB] FAIL reset_counters: got %h/%h expected 00/00", cnt0, cnt1); end
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b%b expected 00", req0_ready, req1_ready); end
    checks++;
    if (out_data !== 16'h0000 || out_src !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_data: got %h/%b expected 0000/0", out_data, out_src); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || mux_sel !== 1'b0) begin
      errors++; $display("[TB] FAIL first_grant: got r0=%b r1=%b sel=%b expected 1 0 0", req0_ready, req1_ready, mux_sel);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== d0 || out_src !== 1'b0) begin
      errors++; $display("[TB] FAIL first_word: got v=%b %h src=%b expected 1 %h 0", out_valid, out_data, out_src, d0);
    end
    checks++;
    if (cnt0 !== 8'h01 || cnt1 !== 8'h00) begin errors++; $display("[TB] FAIL first_counts: got %h/%h expected 01/00", cnt0, cnt1); end
  endtask

  task automatic test_single_source();
    do_reset();
    out_ready  = 1'b1;
    req0_valid = 1'b1;
    req0_data  = 16'h00FF;
    #1;
    checks++;
    if (req1_ready !== 1'b0 || req0_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_ready0: got r0=%b r1=%b expected 1 0", req0_ready, req1_ready); end
    tick();
    checks++;
    if (out_data !== 16'h00FF || out_src !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL single_word0: got %h src=%b v=%b expected 00ff 0 1", out_data, out_src, out_valid);
    end
    req0_data = 16'h0F0F;
    #1;
    checks++;
    if (req1_ready !== 1'b0 || req0_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_ready1: got r0=%b r1=%b expected 1 0", req0_ready, req1_ready); end
    tick();
    checks++;
    if (out_data !== 16'h0F0F || out_src !== 1'b0) begin errors++; $display("[TB] FAIL single_word1: got %h src=%b expected 0f0f 0", out_data, out_src); end
    req0_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0F0F || cnt0 !== 8'h02 || cnt1 !== 8'h00) begin
      errors++; $display("[TB] FAIL single_drain: got v=%b %h cnt=%h/%h expected 0 0f0f 02/00", out_valid, out_data, cnt0, cnt1);
    end
  endtask

  task automatic test_contention();
    logic [15:0] exp_data;
    do_reset();
    out_ready  = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = 16'hAAAA;
    req1_data  = 16'h5555;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (req0_ready !== ((i % 2) == 0) || req1_ready !== ((i % 2) == 1)) begin
        errors++; $display("[TB] FAIL contention_ready[%0d]: got r0=%b r1=%b expected %b %b", i, req0_ready, req1_ready, (i % 2) == 0, (i % 2) == 1);
      end
      tick();
      exp_data = ((i % 2) == 0) ? 16'hAAAA : 16'h5555;
      checks++;
      if (out_data !== exp_data || out_src !== 1'(i % 2)) begin
        errors++; $display("[TB] FAIL contention_word[%0d]: got %h src=%b expected %h %0d", i, out_data, out_src, exp_data, i % 2);
      end
    end
    checks++;
    if (cnt0 !== 8'd3 || cnt1 !== 8'd3) begin errors++; $display("[TB] FAIL contention_counts: got %0d/%0d expected 3/3", cnt0, cnt1); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready  = 1'b1;
    req0_valid = 1'b1;
    req0_data  = 16'h1234;
    tick();
    out_ready  = 1'b0;
    req1_valid = 1'b1;
    req0_data  = 16'h1111;
    req1_data  = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++; $display("[TB] FAIL bp_ready[%0d]: got r0=%b r1=%b expected 0 0", i, req0_ready, req1_ready);
      end
      tick();
      checks++;
      if (out_data !== 16'h1234 || out_valid !== 1'b1 || cnt0 !== 8'd1 || cnt1 !== 8'd0) begin
        errors++; $display("[TB] FAIL bp_hold[%0d]: got %h v=%b cnt=%0d/%0d expected 1234 1 1/0", i, out_data, out_valid, cnt0, cnt1);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_release_ready: got r0=%b r1=%b expected 0 1", req0_ready, req1_ready); end
    tick();
    checks++;
    if (out_data !== 16'h2222 || out_src !== 1'b1 || cnt1 !== 8'd1) begin
      errors++; $display("[TB] FAIL bp_release_word: got %h src=%b cnt1=%0d expected 2222 1 1", out_data, out_src, cnt1);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready  = 1'b1;
    req0_valid = 1'b1;
    req0_data  = 16'hBEEF;
    tick();
    req0_valid = 1'b0;
    out_ready  = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'hBEEF) begin errors++; $display("[TB] FAIL async_pre_hold: got v=%b %h expected 1 beef", out_valid, out_data); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000 || cnt0 !== 8'd0 || mux_sel !== 1'b1) begin
      errors++; $display("[TB] FAIL async_drop: got v=%b %h cnt0=%0d sel=%b expected 0 0000 0 1", out_valid, out_data, cnt0, mux_sel);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || cnt0 !== 8'd0) begin errors++; $display("[TB] FAIL async_idle: got v=%b cnt0=%0d expected 0 0", out_valid, cnt0); end
  endtask

  task automatic test_drop_valid();
    do_reset();
    out_ready  = 1'b1;
    req1_valid = 1'b1;
    req1_data  = 16'h0777;
    tick();
    req1_valid = 1'b0;
    out_ready  = 1'b0;
    tick();
    req0_valid = 1'b1;
    req0_data  = 16'h0333;
    tick();
    req0_valid = 1'b0;
    out_ready  = 1'b1;
    tick();
    tick();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL drop_valid_pointer: got r0=%b r1=%b expected 1 0", req0_ready, req1_ready);
    end
    checks++;
    if (cnt0 !== 8'd0 || cnt1 !== 8'd1) begin errors++; $display("[TB] FAIL drop_valid_counts: got %0d/%0d expected 0/1", cnt0, cnt1); end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    out_ready  = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      req1_data = 16'(i);
      tick();
      if (i == 254) begin
        checks++;
        if (cnt1 !== 8'hFF) begin errors++; $display("[TB] FAIL wrap_ff: got %h expected ff", cnt1); end
      end
    end
    checks++;
    if (cnt1 !== 8'h00 || cnt0 !== 8'h00) begin errors++; $display("[TB] FAIL wrap_zero: got %h/%h expected 00/00", cnt0, cnt1); end
    checks++;
    if (out_data !== 16'h00FF || out_src !== 1'b1) begin errors++; $display("[TB] FAIL wrap_last_word: got %h src=%b expected 00ff 1", out_data, out_src); end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = 16'h0000;
    req1_data  = 16'h0000;
    out_ready  = 1'b0;
    test_reset();
    test_single_source();
    test_contention();
    test_backpressure();
    test_async_reset();
    test_drop_valid();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux16_rr_arbiter.md
Name: mux16_rr_arbiter

Overview:
Shares one 16-bit datapath channel between two requesters, each with a valid/ready handshake. The block decides which source drives the shared 2:1 data mux each cycle and registers the selected word into a one-entry output stage. It holds that word until the downstream consumer accepts it. It sits in front of any single-port 16-bit resource in the processor datapath that two units must time-share.

Parameters:
WIDTH, 16, data width of each requester and of the output channel
CNT_W, 8, width of the per-source accepted-transfer counters

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
req0_valid  input  1  source 0 has a word
req0_data  input  WIDTH  source 0 word
req0_ready  output  1  source 0 word accepted this cycle
req1_valid  input  1  source 1 has a word
req1_data  input  WIDTH  source 1 word
req1_ready  output  1  source 1 word accepted this cycle
out_valid  output  1  output register holds a word
out_data  output  WIDTH  held word
out_src  output  1  source index of the held word
out_ready  input  1  consumer accepts the held word
mux_sel  output  1  current grant; select line of the shared data mux
cnt0  output  CNT_W  words accepted from source 0
cnt1  output  CNT_W  words accepted from source 1

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values:
  - out_valid=0, out_data=0, out_src=0
  - cnt0=0, cnt1=0
  - last_grant=1, so source 0 wins the first tie
  - state=IDLE
- A reset assertion mid-transfer drops the held word immediately. No partial state survives.
- FSM states: IDLE (output empty) and HOLD (output full).
- can_load = (state==IDLE) || out_ready.
- Grant logic (combinational):
  - Only req0_valid high: grant=0.
  - Only req1_valid high: grant=1.
  - Both high: grant = ~last_grant (round robin).
  - Neither high: no grant; mux_sel = last_grant.
- reqN_ready = can_load && reqN_valid && (grant==N). At most one ready is high per cycle.
- Ready depends combinationally on valid and out_ready. Requesters must not make valid depend on ready.
- Transfer on source N when reqN_valid && reqN_ready. On the next edge:
  - out_data <= reqN_data, out_src <= N, out_valid <= 1
  - last_grant <= N
  - cntN increments by 1, wrapping modulo 2^CNT_W
- IDLE transitions:
  - Transfer -> HOLD.
  - No transfer -> stay IDLE; out_data and out_src unchanged.
- HOLD transitions:
  - out_ready=0 -> stay HOLD. out_data and out_src stay stable; no source is readied.
  - out_ready=1 with a transfer the same cycle -> stay HOLD with the new word (back-to-back, 1 word/cycle).
  - out_ready=1 with no transfer -> IDLE, out_valid <= 0.
- Latency: a word accepted on edge k is visible on out_* after edge k, one cycle.
- Fairness:
  - With both sources continuously valid and out_ready=1, grants alternate 0,1,0,1.
  - A source waits at most one transfer of the other source when the consumer is ready.
- A source that drops valid before being readied loses nothing and the grant pointer does not advance.
- Counter wrap: 255+1 -> 0 at CNT_W=8. No saturation or overflow flag.

Decomposition:
- Shared package:
  - State encoding constants: ST_IDLE=1'b0, ST_HOLD=1'b1.
  - Source index constants: SRC0=1'b0, SRC1=1'b1.
  - Default WIDTH and CNT_W.
- One sub-module, rr_pick2: purely combinational grant selection.
  - Inputs: two valids, last_grant. Outputs: grant, any_valid.
- The top level holds:
  - the FSM
  - the output register
  - counters
  - the 2:1 data selection driven by mux_sel

Test Plan:
- Reset: rst_n=0 with both valids high and random data -> out_valid=0, cnt0=cnt1=0, req0_ready=req1_ready=0; after release with out_ready=1, first grant goes to source 0.
- Single source: req0_valid=1 with data 0x00FF, then 0x0F0F, out_ready=1 -> out_data=0x00FF then 0x0F0F on consecutive cycles, out_src=0, cnt0=2, req1_ready never high.
- Contention: both valid, req0_data=0xAAAA, req1_data=0x5555, out_ready=1 for 6 cycles -> out_data sequence AAAA,5555,AAAA,5555,AAAA,5555, cnt0=cnt1=3.
- Backpressure: hold word 0x1234 then set out_ready=0 for 4 cycles with both sources valid -> out_data stays 0x1234, both ready=0, counters frozen; on out_ready=1 the next word loads the same cycle.
- Async reset mid-operation: drop rst_n between clock edges while in HOLD -> out_valid falls immediately without waiting for clk, counters become 0, state IDLE.
- Counter wrap: 256 source-1 transfers -> cnt1 returns to 0x00, cnt0 unchanged.
